// File: rtl/ddr_bias_read_master_pkg.sv
// Shared constants, helper function and FSM state type for the bias DDR read master.
package ddr_bias_read_master_pkg;

  localparam int unsigned DDR_ADDR_LEN = 32;
  localparam int unsigned SINGLE_LEN   = 24;
  localparam int unsigned BUS_WIDTH    = 128;
  localparam int unsigned MAX_BURST    = 16;
  localparam int unsigned FIFO_DEPTH   = 64;
  localparam int unsigned LVL_LEN      = 7;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) res = res + 1;
    return res;
  endfunction

  localparam int unsigned BUS_BYTES  = BUS_WIDTH / 8;
  localparam int unsigned AXI_SIZE   = clogb2(BUS_BYTES);
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_W     = clogb2(PAGE_BYTES);
  localparam int unsigned PAGE_BEATS = PAGE_BYTES / BUS_BYTES;
  localparam int unsigned PB_W       = clogb2(PAGE_BEATS) + 1;
  localparam int unsigned BEAT_W     = clogb2(MAX_BURST) + 1;
  localparam int unsigned OUT_W      = LVL_LEN;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ddr_bias_read_master_if.sv
// AXI4 read-channel bundle between the bias read master and the DDR interconnect.
interface ddr_bias_read_master_if;
  import ddr_bias_read_master_pkg::*;

  logic [DDR_ADDR_LEN-1:0] m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [BUS_WIDTH-1:0]    m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

endinterface

// File: rtl/ddr_burst_split.sv
// Next burst length: min(remaining beats, MAX_BURST, beats left in the current 4 KB page).
module ddr_burst_split
  import ddr_bias_read_master_pkg::*;
(
  input  logic [DDR_ADDR_LEN-1:0] i_addr,
  input  logic [SINGLE_LEN-1:0]   i_remaining,
  output logic [BEAT_W-1:0]       o_beats_c
);

  logic [PB_W-1:0]   w_page_beats;
  logic [BEAT_W-1:0] w_cap;
  logic              w_unused_addr;

  assign w_page_beats  = PB_W'(PAGE_BEATS) - PB_W'(i_addr[PAGE_W-1:AXI_SIZE]);
  assign w_unused_addr = ^{i_addr[DDR_ADDR_LEN-1:PAGE_W], i_addr[AXI_SIZE-1:0]};

  always_comb begin
    w_cap     = BEAT_W'(MAX_BURST);
    if (i_remaining < SINGLE_LEN'(MAX_BURST)) w_cap = BEAT_W'(i_remaining);
    o_beats_c = w_cap;
    if (w_page_beats < PB_W'(w_cap)) o_beats_c = BEAT_W'(w_page_beats);
  end

endmodule

// File: rtl/ddr_bias_read_master.sv
// AXI4 read master feeding the bias DDR FIFO: splits a byte request into 4 KB-safe INCR bursts,
// issued only with guaranteed FIFO credit. Macro RRESP_CHECK_EN enables the sticky rresp error flag.
module ddr_bias_read_master
  import ddr_bias_read_master_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]   ddr_len,
  ddr_bias_read_master_if.master  m_axi,
  output logic                    fifo_wr_en,
  output logic [BUS_WIDTH-1:0]    fifo_din,
  input  logic [LVL_LEN-1:0]      fifo_level,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned LEN_W = SINGLE_LEN + 1;
  localparam int unsigned CW    = LVL_LEN + OUT_W + BEAT_W;

  state_e                  r_state;
  logic [DDR_ADDR_LEN-1:0] r_addr;
  logic [SINGLE_LEN-1:0]   r_remaining;
  logic [BEAT_W-1:0]       r_beats;
  logic [7:0]              r_arlen;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_wr_en;
  logic [BUS_WIDTH-1:0]    r_din;
  logic [OUT_W-1:0]        r_outstanding;

  logic [DDR_ADDR_LEN-1:0] w_start_addr;
  logic [LEN_W-1:0]        w_len_round;
  logic [SINGLE_LEN-1:0]   w_total_beats;
  logic [SINGLE_LEN-1:0]   w_rem_next;
  logic [BEAT_W-1:0]       w_split_beats;
  logic [CW-1:0]           w_need;
  logic                    w_credit_ok;
  logic                    w_ar_hs;
  logic                    w_beat;
  logic                    w_conf_acc;
  logic                    w_unused;

  assign w_start_addr  = {ddr_st_addr[DDR_ADDR_LEN-1:AXI_SIZE], {AXI_SIZE{1'b0}}};
  assign w_len_round   = LEN_W'(ddr_len) + LEN_W'(BUS_BYTES - 1);
  assign w_total_beats = SINGLE_LEN'(w_len_round >> AXI_SIZE);
  assign w_rem_next    = r_remaining - SINGLE_LEN'(r_beats);
  assign w_conf_acc    = ddr_conf && (r_state == ST_IDLE) && !r_busy;
  assign w_ar_hs       = r_arvalid && m_axi.m_axi_arready;
  assign w_beat        = m_axi.m_axi_rvalid && r_rready;

  // One spare beat covers the up-to-one-cycle lag of fifo_level.
  assign w_need      = CW'(fifo_level) + CW'(r_outstanding) + CW'(r_beats) + CW'(1);
  assign w_credit_ok = (w_need <= CW'(FIFO_DEPTH));

  ddr_burst_split u_split (
    .i_addr      (r_addr),
    .i_remaining (r_remaining),
    .o_beats_c   (w_split_beats)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_beats       <= '0;
      r_arlen       <= '0;
      r_arvalid     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_ar_hs) r_outstanding <= r_outstanding + OUT_W'(r_beats) - OUT_W'(w_beat);
      else         r_outstanding <= r_outstanding - OUT_W'(w_beat);

      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (w_conf_acc) begin
            r_addr      <= w_start_addr;
            r_remaining <= w_total_beats;
            if (ddr_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_beats <= w_split_beats;
          r_arlen <= 8'(w_split_beats - BEAT_W'(1));
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Address/length stay frozen while arvalid is waiting for arready.
          if (!r_arvalid) begin
            if (w_credit_ok) r_arvalid <= 1'b1;
          end else if (m_axi.m_axi_arready) begin
            r_arvalid   <= 1'b0;
            r_addr      <= r_addr + (DDR_ADDR_LEN'(r_beats) << AXI_SIZE);
            r_remaining <= w_rem_next;
            r_state     <= (w_rem_next != '0) ? ST_CALC : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_outstanding == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write path: every accepted beat lands in the FIFO one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rready <= 1'b0;
      r_wr_en  <= 1'b0;
      r_din    <= '0;
    end else begin
      r_rready <= 1'b1;
      r_wr_en  <= w_beat;
      r_din    <= m_axi.m_axi_rdata;
    end
  end

`ifdef RRESP_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst)                                          r_err <= 1'b0;
    else if (w_conf_acc)                              r_err <= 1'b0;
    else if (w_beat && (m_axi.m_axi_rresp != 2'b00)) r_err <= 1'b1;
  end

  assign err      = r_err;
  assign w_unused = ^{ddr_st_addr[AXI_SIZE-1:0], m_axi.m_axi_rlast};
`else
  assign err      = 1'b0;
  assign w_unused = ^{ddr_st_addr[AXI_SIZE-1:0], m_axi.m_axi_rlast, m_axi.m_axi_rresp};
`endif

  assign m_axi.m_axi_araddr  = r_addr;
  assign m_axi.m_axi_arlen   = r_arlen;
  assign m_axi.m_axi_arsize  = 3'(AXI_SIZE);
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arvalid = r_arvalid;
  assign m_axi.m_axi_rready  = r_rready;
  assign fifo_wr_en          = r_wr_en;
  assign fifo_din            = r_din;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

// File: tb/tb_ddr_bias_read_master.sv
// Directed bench for ddr_bias_read_master: AXI slave model plus scoreboard of AR bursts and FIFO beats.
module tb_ddr_bias_read_master;
  import ddr_bias_read_master_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          ddr_conf;
  logic [31:0]   ddr_st_addr;
  logic [23:0]   ddr_len;
  logic          fifo_wr_en;
  logic [127:0]  fifo_din;
  logic [6:0]    fifo_level;
  logic          busy;
  logic          done;
  logic          err;

  ddr_bias_read_master_if axi();

  ddr_bias_read_master dut (
    .clk         (clk),
    .rst         (rst),
    .ddr_conf    (ddr_conf),
    .ddr_st_addr (ddr_st_addr),
    .ddr_len     (ddr_len),
    .m_axi       (axi),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

`ifdef RRESP_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  int total, bad, cyc;
  int n_wr, n_done, n_ar, done_cyc, last_wr_cyc, conf_cyc;
  int beat_idx, xfer_beat;
  bit saw_busy, arv_seen, err_seen, busy_at_done;
  bit beat_acc, prev_beat, prev_arv, gap_en, arready_en, rresp_inject;
  logic [31:0]  prev_araddr;
  logic [7:0]   prev_arlen;
  logic [31:0]  exp_ar_addr[$];
  logic [7:0]   exp_ar_len[$];
  logic [31:0]  pend_addr[$];
  int           pend_beats[$];
  logic [127:0] exp_data[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: scoreboard pops on FIFO pushes, AR handshakes checked against the plan.
  task automatic sample();
    logic [31:0]  ea;
    logic [7:0]   el;
    logic [127:0] ed;
    logic [31:0]  endv;
    if (rst) begin
      prev_beat = 1'b0;
      prev_arv  = 1'b0;
      beat_acc  = 1'b0;
      return;
    end
    if (fifo_wr_en || prev_beat) check_i("wr_latency", int'(fifo_wr_en), int'(prev_beat));
    if (fifo_wr_en) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (exp_data.size() == 0) check_i("wr_unexpected", 1, 0);
      else begin
        ed = exp_data.pop_front();
        check("wr_data", fifo_din, ed);
      end
    end
    if (prev_arv && axi.m_axi_arvalid) begin
      check("ar_stable_addr", 128'(axi.m_axi_araddr), 128'(prev_araddr));
      check("ar_stable_len", 128'(axi.m_axi_arlen), 128'(prev_arlen));
    end
    if (axi.m_axi_arvalid) arv_seen = 1'b1;
    if (axi.m_axi_arvalid && axi.m_axi_arready) begin
      n_ar++;
      if (exp_ar_addr.size() == 0) check_i("ar_unexpected", 1, 0);
      else begin
        ea = exp_ar_addr.pop_front();
        el = exp_ar_len.pop_front();
        check("ar_addr", 128'(axi.m_axi_araddr), 128'(ea));
        check("ar_len", 128'(axi.m_axi_arlen), 128'(el));
      end
      endv = 32'(axi.m_axi_araddr[11:0]) + ((32'(axi.m_axi_arlen) + 32'd1) << 4);
      check_i("ar_no_4k_cross", int'(endv <= 32'd4096), 1);
      pend_addr.push_back(axi.m_axi_araddr);
      pend_beats.push_back(int'(axi.m_axi_arlen) + 1);
    end
    beat_acc = axi.m_axi_rvalid && axi.m_axi_rready;
    if (beat_acc) exp_data.push_back(axi.m_axi_rdata);
    prev_beat   = beat_acc;
    prev_arv    = axi.m_axi_arvalid && !axi.m_axi_arready;
    prev_araddr = axi.m_axi_araddr;
    prev_arlen  = axi.m_axi_arlen;
    if (busy) saw_busy = 1'b1;
    if (err) err_seen = 1'b1;
    if (done) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  endtask

  // Slave model: R beats follow accepted ARs in order, optional random gaps.
  task automatic drive();
    logic [31:0] a;
    cyc++;
    if (beat_acc) begin
      beat_idx++;
      xfer_beat++;
      if (beat_idx == pend_beats[0]) begin
        void'(pend_addr.pop_front());
        void'(pend_beats.pop_front());
        beat_idx = 0;
      end
    end
    beat_acc = 1'b0;
    if (pend_addr.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      a = pend_addr[0] + 32'(beat_idx * 16);
      axi.m_axi_rvalid = 1'b1;
      axi.m_axi_rdata  = {a, 32'(xfer_beat), 32'(cyc) ^ 32'hC0DE_0000, ~a};
      axi.m_axi_rresp  = (rresp_inject && xfer_beat == 2) ? 2'b10 : 2'b00;
      axi.m_axi_rlast  = (beat_idx == pend_beats[0] - 1);
    end else begin
      axi.m_axi_rvalid = 1'b0;
      axi.m_axi_rdata  = '0;
      axi.m_axi_rresp  = 2'b00;
      axi.m_axi_rlast  = 1'b0;
    end
    axi.m_axi_arready = arready_en && (!gap_en || $urandom_range(0, 1) == 1);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic start(input logic [31:0] a, input logic [23:0] l);
    ddr_st_addr = a;
    ddr_len     = l;
    ddr_conf    = 1'b1;
    xfer_beat   = 0;
    conf_cyc    = cyc;
    tick();
    ddr_conf    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    check_i(tag, int'(n_done != d0), 1);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar_addr.push_back(a);
    exp_ar_len.push_back(l);
  endtask

  initial begin
    int d_wr, d_ar, d_done, k;
    total = 0; bad = 0; cyc = 0;
    n_wr = 0; n_done = 0; n_ar = 0; done_cyc = 0; last_wr_cyc = 0; conf_cyc = 0;
    beat_idx = 0; xfer_beat = 0;
    saw_busy = 0; arv_seen = 0; err_seen = 0; busy_at_done = 0;
    beat_acc = 0; prev_beat = 0; prev_arv = 0; gap_en = 0; arready_en = 1; rresp_inject = 0;
    prev_araddr = '0; prev_arlen = '0;
    rst = 1'b1; ddr_conf = 1'b0; ddr_st_addr = '0; ddr_len = '0; fifo_level = '0;
    axi.m_axi_arready = 1'b0; axi.m_axi_rdata = '0; axi.m_axi_rresp = 2'b00;
    axi.m_axi_rlast = 1'b0; axi.m_axi_rvalid = 1'b0;

    // Reset values
    repeat (3) tick();
    check_i("rst_arvalid", int'(axi.m_axi_arvalid), 0);
    check_i("rst_rready", int'(axi.m_axi_rready), 0);
    check_i("rst_wr_en", int'(fifo_wr_en), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    check_i("rst_err", int'(err), 0);
    check_i("arsize", int'(axi.m_axi_arsize), 4);
    check_i("arburst", int'(axi.m_axi_arburst), 1);
    rst = 1'b0;
    repeat (2) tick();
    check_i("rready_after_rst", int'(axi.m_axi_rready), 1);

    // Single aligned 16-beat burst
    d_wr = n_wr; d_ar = n_ar; d_done = n_done;
    push_ar(32'h0000_1000, 8'd15);
    start(32'h0000_1000, 24'd256);
    wait_done("t1_done_timeout", 200);
    check_i("t1_beats", n_wr - d_wr, 16);
    check_i("t1_ars", n_ar - d_ar, 1);
    check_i("t1_done_after_push", done_cyc, last_wr_cyc + 1);
    check_i("t1_latency", done_cyc - conf_cyc, 21);
    check_i("t1_busy_at_done", int'(busy_at_done), 1);
    check_i("t1_busy_low_after", int'(busy), 0);
    check_i("t1_done_pulse", int'(done), 0);
    repeat (3) tick();
    check_i("t1_done_count", n_done - d_done, 1);

    // 4 KB split with random rvalid/arready gaps
    gap_en = 1;
    d_wr = n_wr; d_ar = n_ar;
    push_ar(32'h0000_0FC0, 8'd3);
    push_ar(32'h0000_1000, 8'd15);
    push_ar(32'h0000_1100, 8'd11);
    start(32'h0000_0FC0, 24'd512);
    wait_done("t2_done_timeout", 600);
    check_i("t2_beats", n_wr - d_wr, 32);
    check_i("t2_ars", n_ar - d_ar, 3);
    gap_en = 0;
    repeat (2) tick();

    // FIFO credit gating
    fifo_level = 7'd60;
    arv_seen = 0; d_wr = n_wr;
    push_ar(32'h0000_2000, 8'd15);
    start(32'h0000_2000, 24'd256);
    repeat (20) tick();
    check_i("t3_block_at_60", int'(arv_seen), 0);
    fifo_level = 7'd48;
    repeat (5) tick();
    check_i("t3_block_at_48", int'(arv_seen), 0);
    fifo_level = 7'd47;
    k = 0;
    while (!arv_seen && k < 10) begin tick(); k++; end
    check_i("t3_open_at_47", int'(arv_seen), 1);
    wait_done("t3_done_timeout", 200);
    check_i("t3_beats", n_wr - d_wr, 16);
    fifo_level = 7'd0;
    repeat (2) tick();

    // Zero-length request
    saw_busy = 0; d_ar = n_ar; d_done = n_done;
    start(32'h0000_3000, 24'd0);
    check_i("t4_done_next", int'(done), 1);
    check_i("t4_busy", int'(busy), 0);
    tick();
    check_i("t4_done_one_cycle", int'(done), 0);
    repeat (3) tick();
    check_i("t4_done_count", n_done - d_done, 1);
    check_i("t4_no_ar", n_ar - d_ar, 0);
    check_i("t4_busy_never", int'(saw_busy), 0);

    // ddr_conf while busy is ignored
    d_wr = n_wr; d_ar = n_ar; d_done = n_done;
    push_ar(32'h0000_4000, 8'd15);
    start(32'h0000_4000, 24'd256);
    repeat (3) tick();
    ddr_st_addr = 32'h0000_5000; ddr_len = 24'd512; ddr_conf = 1'b1;
    tick();
    ddr_conf = 1'b0;
    wait_done("t5_done_timeout", 200);
    check_i("t5_latency", done_cyc - conf_cyc, 21);
    check_i("t5_beats", n_wr - d_wr, 16);
    check_i("t5_ars", n_ar - d_ar, 1);
    repeat (5) tick();
    check_i("t5_done_count", n_done - d_done, 1);
    check_i("t5_no_extra_busy", int'(busy), 0);

    // Reset after the second AR handshake
    d_ar = n_ar;
    push_ar(32'h0000_6000, 8'd15);
    push_ar(32'h0000_6100, 8'd15);
    start(32'h0000_6000, 24'd1024);
    k = 0;
    while ((n_ar - d_ar) < 2 && k < 200) begin tick(); k++; end
    check_i("t6_two_ars", n_ar - d_ar, 2);
    rst = 1'b1;
    pend_addr.delete(); pend_beats.delete(); beat_idx = 0; beat_acc = 1'b0;
    axi.m_axi_rvalid = 1'b0; axi.m_axi_rdata = '0; axi.m_axi_rlast = 1'b0;
    tick();
    exp_data.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    check_i("t6_rst_arvalid", int'(axi.m_axi_arvalid), 0);
    check_i("t6_rst_rready", int'(axi.m_axi_rready), 0);
    check_i("t6_rst_wr_en", int'(fifo_wr_en), 0);
    check_i("t6_rst_busy", int'(busy), 0);
    check_i("t6_rst_done", int'(done), 0);
    check("t6_rst_araddr", 128'(axi.m_axi_araddr), 128'd0);
    check("t6_rst_din", fifo_din, 128'd0);
    rst = 1'b0;
    arv_seen = 0; d_ar = n_ar;
    repeat (5) tick();
    check_i("t6_no_ar_after_rst", int'(arv_seen), 0);
    d_wr = n_wr;
    push_ar(32'h0000_7000, 8'd15);
    start(32'h0000_7000, 24'd256);
    wait_done("t6_done_timeout", 200);
    check_i("t6_clean_beats", n_wr - d_wr, 16);
    check_i("t6_clean_ars", n_ar - d_ar, 1);

    // Response error on beat 3
    rresp_inject = 1; err_seen = 0; d_wr = n_wr;
    push_ar(32'h0000_8000, 8'd15);
    start(32'h0000_8000, 24'd256);
    wait_done("t7_done_timeout", 200);
    repeat (2) tick();
    check_i("t7_beats", n_wr - d_wr, 16);
    check_i("t7_err_sticky", int'(err), EXP_ERR);
    check_i("t7_err_seen", int'(err_seen), EXP_ERR);
    rresp_inject = 0;
    start(32'h0000_9000, 24'd0);
    check_i("t7_err_cleared", int'(err), 0);
    repeat (2) tick();

    check_i("sb_empty", exp_data.size(), 0);
    check_i("ar_plan_empty", exp_ar_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_bias_read_master.md
Name: ddr_bias_read_master

Overview:
- AXI4 read master that feeds the bias DDR FIFO.
- Accepts one transfer request per configuration pulse: start address and byte length, driven by the bias FIFO control's ddr_conf / ddr_st_addr_out / ddr_len outputs.
- Splits the request into AXI4 INCR bursts and pushes returned beats into the FIFO that the bias FIFO control drains.
- Issues a burst only when FIFO space is guaranteed, so rready is held high and no data is ever dropped.

Parameters:
- DDR_ADDR_LEN, 32, AXI address width.
- SINGLE_LEN, 24, byte-length field width.
- BUS_WIDTH, 128, AXI/FIFO data width in bits (DATA_LEN*BUFFER_NUM).
- MAX_BURST, 16, maximum beats per burst (power of 2, ≤256).
- FIFO_DEPTH, 64, downstream FIFO depth in beats.
- LVL_LEN, 7, width of the FIFO level input (clog2(FIFO_DEPTH)+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ddr_conf  in  1  start pulse, one cycle.
- ddr_st_addr  in  DDR_ADDR_LEN  start byte address.
- ddr_len  in  SINGLE_LEN  transfer length in bytes.
- m_axi_araddr  out  DDR_ADDR_LEN  burst address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant log2(BUS_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address accepted.
- m_axi_rdata  in  BUS_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of a burst.
- m_axi_rvalid  in  1  data valid.
- m_axi_rready  out  1  data ready.
- fifo_wr_en  out  1  FIFO push.
- fifo_din  out  BUS_WIDTH  FIFO write data.
- fifo_level  in  LVL_LEN  current FIFO occupancy in beats.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky response error.

Behaviour:
- Reset and clocking:
  - Single clock clk; rst is synchronous and active-high.
  - On rst, all outputs go to 0 except m_axi_arsize and m_axi_arburst, which are constant. All counters clear, FSM goes to IDLE.
  - rst mid-transfer abandons the transfer and issues no further AR. Interconnect and FIFO share the same reset.
- Request capture:
  - Address low log2(BUS_WIDTH/8) bits are forced to 0.
  - total_beats = ceil(ddr_len / (BUS_WIDTH/8)).
  - ddr_len = 0 produces done on the cycle after ddr_conf, with no AR issued.
  - ddr_conf while busy is ignored.
- FSM states:
  - IDLE → CALC on ddr_conf.
  - CALC: beats = min(remaining_beats, MAX_BURST, beats to next 4 KB boundary). → ISSUE.
  - ISSUE: arvalid=1 only when FIFO_DEPTH - fifo_level - outstanding ≥ beats. arvalid, araddr and arlen stay stable until arready.
    - On arready: outstanding += beats, addr += beats*bytes, remaining -= beats.
    - Then → CALC if remaining > 0, else → DRAIN.
  - DRAIN: wait until outstanding = 0, then → IDLE with done=1 for one cycle.
- busy is 1 from the cycle after ddr_conf until the done cycle, inclusive.
- m_axi_rready is constant 1 while not in reset; the credit check guarantees space.
- Write path:
  - Each beat with rvalid produces fifo_wr_en=1 and fifo_din=rdata on the next cycle (1-cycle registered latency).
  - outstanding decrements by 1 per accepted beat.
  - An AR handshake and an R beat in the same cycle update outstanding by +beats-1.
- rlast is not used for counting; beats are counted.
- fifo_level is treated as the true occupancy, which may lag by up to 1 cycle. The credit check adds 1 beat of margin: issue only when free-1 ≥ beats.
- Arithmetic: address and remaining-beat counters wrap modulo their widths. No crossing of a 4 KB boundary ever occurs.

Optional Feature:
- Macro RRESP_CHECK_EN.
- Defined: err sets on any accepted beat with rresp ≠ 2'b00 and clears only on rst or the next ddr_conf. Data is still pushed.
- Undefined: err is tied 0 and rresp is unused.

Decomposition:
- Shared package: AXI burst/size constants, the clogb2 function, the 4 KB page constant, and the beats-per-bus-word constant.
- One sub-module, ddr_burst_split: combinational/registered computation of the next burst length from address, remaining beats and MAX_BURST.

Test Plan:
- addr 0x1000, len 256 (16 beats), arready always 1 → one AR, arlen=15; 16 fifo_wr_en pulses; done after the last push; busy low afterwards.
- addr 0x0FC0, len 512 (32 beats) → bursts: 4 beats @0x0FC0, 16 beats @0x1000, 12 beats @0x1100. No 4 KB crossing.
- fifo_level held at 60 with FIFO_DEPTH 64, len 256 → no arvalid until fifo_level ≤ 47, then AR issued.
- len 0 → done 1 cycle after ddr_conf, no AR, busy never high.
- ddr_conf pulsed again mid-transfer → ignored; beat count and done timing unchanged.
- rst asserted after the 2nd AR handshake → all outputs 0 next cycle. A new ddr_conf then runs a clean 16-beat transfer.
- With RRESP_CHECK_EN: rresp=2'b10 on beat 3 → err=1 sticky and all 16 beats still pushed. Without the macro, err stays 0.
